// File: rtl/dm_responder.sv
// Handshaked, wait-stated 32-bit word memory with byte-enabled stores.
// Optional store trace compiled in when DM_RESPONDER_TRACE_EN is defined.
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                we_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [31:0]         wdata_reg;
    logic [3:0]          be_reg;
    logic [31:0]         pc_reg;
    logic                accept;
    logic                commit;
    logic                op_we;
    logic [ADDR_W-1:0]   op_idx;
    logic [31:0]         op_wdata;
    logic [3:0]          op_be;
    logic [31:0]         merged;
    logic [31:0]         mem [DEPTH];
    logic                unused_bits;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state_next == RESP) && (state_reg != RESP);

    // With zero wait states the access commits on its own acceptance edge,
    // before the latch registers hold it, so take the live inputs then.
    assign op_we    = accept ? we                  : we_reg;
    assign op_idx   = accept ? addr[ADDR_W+1:2]    : idx_reg;
    assign op_wdata = accept ? wdata               : wdata_reg;
    assign op_be    = accept ? be                  : be_reg;

    always_comb begin
        merged = mem[op_idx];
        for (int i = 0; i < 4; i++)
            if (op_be[i]) merged[8*i +: 8] = op_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            pc_reg    <= '0;
            rdata     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= we;
                idx_reg   <= addr[ADDR_W+1:2];
                wdata_reg <= wdata;
                be_reg    <= be;
                pc_reg    <= pc;
            end
            if (commit && !op_we) rdata <= mem[op_idx];
        end
    end

    // Per-word storage so that reset can clear the whole array.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                mem[gi] <= '0;
            else if (commit && op_we && (op_idx == ADDR_W'(gi)))
                mem[gi] <= merged;
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == RESP);

    assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0], pc_reg};

`ifdef DM_RESPONDER_TRACE_EN
    logic [31:0] op_pc;
    logic [31:0] trace_addr;
    assign op_pc      = accept ? pc : pc_reg;
    assign trace_addr = {{(30-ADDR_W){1'b0}}, op_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (reset && commit && op_we)
            $display("@%08h: *%08h <= %08h", op_pc, trace_addr, merged);
    end
`endif

endmodule
